// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for a MIPS subset (R/ADDI/ORI/BEQ/LW/SW).
// Inputs: clk_i, rst_i, instr_op_i, mem_ready_i, zero_i.
// Outputs: datapath controls, state_o, retire_cnt_o, illegal_op_o, bus_err_o.
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [5:0]  instr_op_i,
    input  logic        mem_ready_i,
    input  logic        zero_i,
    output logic        IM_read_o,
    output logic        DM_read_o,
    output logic        DM_write_o,
    output logic        IR_write_o,
    output logic        PC_write_o,
    output logic        PC_write_cond_o,
    output logic        PC_src_sel_o,
    output logic        ALU_src1_sel_o,
    output logic [1:0]  ALU_src2_sel_o,
    output logic [1:0]  ALU_ctrl_o,
    output logic        ext_sel_o,
    output logic        reg_w1_addr_sel_o,
    output logic        reg_w1_data_sel_o,
    output logic        reg_write_o,
    output logic [2:0]  state_o,
    output logic [31:0] retire_cnt_o,
    output logic        illegal_op_o,
    output logic        bus_err_o
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd7;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;

    logic [2:0]       state;
    logic [2:0]       state_nx;
    logic [5:0]       op_q;
    logic [CNT_W-1:0] wait_cnt;
    logic             in_acc;
    logic             timeout;
    logic             legal;
    logic             retire;

    // The zero flag is consumed by the datapath, not by this FSM.
    logic unused_zero;
    assign unused_zero = zero_i;

    assign state_o = state;
    assign in_acc  = (state == S_FETCH) || (state == S_MEM);
    // Ready in the final allowed cycle still counts as a normal completion.
    assign timeout = in_acc && !mem_ready_i &&
                     (wait_cnt == CNT_W'(MEM_TIMEOUT - 1));
    assign retire  = (state_nx == S_FETCH) &&
                     ((state == S_EXEC) || (state == S_MEM) ||
                      (state == S_WB));

    always_comb begin
        legal = 1'b0;
        case (instr_op_i)
            OP_R, OP_ADDI, OP_ORI,
            OP_BEQ, OP_LW, OP_SW: legal = 1'b1;
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_FETCH: begin
                if (mem_ready_i)  state_nx = S_DECODE;
                else if (timeout) state_nx = S_HALT;
            end
            S_DECODE: state_nx = legal ? S_EXEC : S_HALT;
            S_EXEC: begin
                case (op_q)
                    OP_LW, OP_SW: state_nx = S_MEM;
                    OP_BEQ:       state_nx = S_FETCH;
                    default:      state_nx = S_WB;
                endcase
            end
            S_MEM: begin
                if (mem_ready_i)
                    state_nx = (op_q == OP_LW) ? S_WB : S_FETCH;
                else if (timeout)
                    state_nx = S_HALT;
            end
            S_WB:    state_nx = S_FETCH;
            S_HALT:  state_nx = S_HALT;
            default: state_nx = S_HALT;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= S_FETCH;
            op_q         <= '0;
            wait_cnt     <= '0;
            retire_cnt_o <= '0;
            illegal_op_o <= 1'b0;
            bus_err_o    <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == S_DECODE)
                op_q <= instr_op_i;
            // Outside FETCH/MEM the counter rests at zero, so every new
            // access starts from a cleared count.
            if (in_acc && !mem_ready_i)
                wait_cnt <= wait_cnt + 1'b1;
            else
                wait_cnt <= '0;
            if (retire)
                retire_cnt_o <= retire_cnt_o + 32'd1;
            if (state == S_DECODE && !legal)
                illegal_op_o <= 1'b1;
            if (timeout)
                bus_err_o <= 1'b1;
        end
    end

    always_comb begin
        IM_read_o         = 1'b0;
        DM_read_o         = 1'b0;
        DM_write_o        = 1'b0;
        IR_write_o        = 1'b0;
        PC_write_o        = 1'b0;
        PC_write_cond_o   = 1'b0;
        PC_src_sel_o      = 1'b0;
        ALU_src1_sel_o    = 1'b0;
        ALU_src2_sel_o    = 2'b00;
        ALU_ctrl_o        = 2'b00;
        ext_sel_o         = 1'b0;
        reg_w1_addr_sel_o = 1'b0;
        reg_w1_data_sel_o = 1'b0;
        reg_write_o       = 1'b0;
        if (!rst_i) begin
            case (state)
                S_FETCH: begin
                    IM_read_o      = 1'b1;
                    ALU_src2_sel_o = 2'b01;
                    IR_write_o     = mem_ready_i;
                    PC_write_o     = mem_ready_i;
                end
                S_DECODE: ALU_src2_sel_o = 2'b11;
                S_EXEC: begin
                    ALU_src1_sel_o = 1'b1;
                    case (op_q)
                        OP_R: ALU_ctrl_o = 2'b10;
                        OP_ORI: begin
                            ALU_src2_sel_o = 2'b10;
                            ALU_ctrl_o     = 2'b11;
                            ext_sel_o      = 1'b1;
                        end
                        OP_BEQ: begin
                            ALU_ctrl_o      = 2'b01;
                            PC_write_cond_o = 1'b1;
                            PC_src_sel_o    = 1'b1;
                        end
                        default: ALU_src2_sel_o = 2'b10;
                    endcase
                end
                S_MEM: begin
                    DM_read_o  = (op_q == OP_LW);
                    DM_write_o = (op_q == OP_SW);
                end
                S_WB: begin
                    reg_write_o       = 1'b1;
                    reg_w1_addr_sel_o = (op_q == OP_R);
                    reg_w1_data_sel_o = (op_q == OP_LW);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed, table-driven bench for multicycle_ctrl.
// Checks state, controls, retire count and sticky flags.
module tb_multicycle_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [5:0]  instr_op_i = '0;
  logic        mem_ready_i = 1'b0;
  logic        zero_i = 1'b0;
  logic        IM_read_o, DM_read_o;
  logic        DM_write_o, IR_write_o;
  logic        PC_write_o, PC_write_cond_o;
  logic        PC_src_sel_o;
  logic        ALU_src1_sel_o;
  logic [1:0]  ALU_src2_sel_o, ALU_ctrl_o;
  logic        ext_sel_o;
  logic        reg_w1_addr_sel_o;
  logic        reg_w1_data_sel_o;
  logic        reg_write_o;
  logic [2:0]  state_o;
  logic [31:0] retire_cnt_o;
  logic        illegal_op_o, bus_err_o;

  always #5 clk_i = ~clk_i;

  multicycle_ctrl #(
    .MEM_TIMEOUT(16),
    .CNT_W(5)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .instr_op_i(instr_op_i),
    .mem_ready_i(mem_ready_i),
    .zero_i(zero_i),
    .IM_read_o(IM_read_o),
    .DM_read_o(DM_read_o),
    .DM_write_o(DM_write_o),
    .IR_write_o(IR_write_o),
    .PC_write_o(PC_write_o),
    .PC_write_cond_o(PC_write_cond_o),
    .PC_src_sel_o(PC_src_sel_o),
    .ALU_src1_sel_o(ALU_src1_sel_o),
    .ALU_src2_sel_o(ALU_src2_sel_o),
    .ALU_ctrl_o(ALU_ctrl_o),
    .ext_sel_o(ext_sel_o),
    .reg_w1_addr_sel_o(reg_w1_addr_sel_o),
    .reg_w1_data_sel_o(reg_w1_data_sel_o),
    .reg_write_o(reg_write_o),
    .state_o(state_o),
    .retire_cnt_o(retire_cnt_o),
    .illegal_op_o(illegal_op_o),
    .bus_err_o(bus_err_o)
  );

  logic [15:0] ctrl;
  assign ctrl = {IM_read_o, DM_read_o,
                 DM_write_o, IR_write_o,
                 PC_write_o, PC_write_cond_o,
                 PC_src_sel_o, ALU_src1_sel_o,
                 ALU_src2_sel_o, ALU_ctrl_o,
                 ext_sel_o, reg_w1_addr_sel_o,
                 reg_w1_data_sel_o, reg_write_o};

  localparam logic [15:0] C_NONE  = 16'h0000;
  localparam logic [15:0] C_FWAIT = 16'h8040;
  localparam logic [15:0] C_FRDY  = 16'h9840;
  localparam logic [15:0] C_DEC   = 16'h00C0;
  localparam logic [15:0] C_EX_R  = 16'h0120;
  localparam logic [15:0] C_EX_AD = 16'h0180;
  localparam logic [15:0] C_EX_OR = 16'h01B8;
  localparam logic [15:0] C_EX_BQ = 16'h0710;
  localparam logic [15:0] C_M_LW  = 16'h4000;
  localparam logic [15:0] C_M_SW  = 16'h2000;
  localparam logic [15:0] C_WB_R  = 16'h0005;
  localparam logic [15:0] C_WB_I  = 16'h0001;
  localparam logic [15:0] C_WB_LW = 16'h0003;

  localparam logic [5:0] R    = 6'h00;
  localparam logic [5:0] ADDI = 6'h08;
  localparam logic [5:0] ORI  = 6'h0D;
  localparam logic [5:0] BEQ  = 6'h04;
  localparam logic [5:0] LW   = 6'h23;
  localparam logic [5:0] SW   = 6'h2B;
  localparam logic [5:0] JMP  = 6'h02;

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic        rdy;
    int          rep;
    logic [2:0]  st;
    logic [15:0] c;
    logic [31:0] ret;
    logic [1:0]  fl;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic add(
    input logic        r,
    input logic [5:0]  op,
    input logic        rdy,
    input int          rep,
    input logic [2:0]  st,
    input logic [15:0] c,
    input logic [31:0] ret,
    input logic [1:0]  fl
  );
    vec_t v;
    v.rst = r;
    v.op  = op;
    v.rdy = rdy;
    v.rep = rep;
    v.st  = st;
    v.c   = c;
    v.ret = ret;
    v.fl  = fl;
    tbl.push_back(v);
  endtask

  initial begin
    add(1, R, 0, 1, 0, C_NONE, 0, 2'b00);
    add(0, R, 1, 1, 0, C_FRDY, 0, 2'b00);
    add(0, R, 1, 1, 1, C_DEC, 0, 2'b00);
    add(0, R, 1, 1, 2, C_EX_R, 0, 2'b00);
    add(0, R, 1, 1, 4, C_WB_R, 0, 2'b00);
    add(0, ADDI, 1, 1, 0, C_FRDY, 1, 2'b00);
    add(0, ADDI, 1, 1, 1, C_DEC, 1, 2'b00);
    add(0, ADDI, 1, 1, 2, C_EX_AD, 1, 2'b00);
    add(0, ADDI, 1, 1, 4, C_WB_I, 1, 2'b00);
    add(0, LW, 0, 3, 0, C_FWAIT, 2, 2'b00);
    add(0, LW, 1, 1, 0, C_FRDY, 2, 2'b00);
    add(0, LW, 1, 1, 1, C_DEC, 2, 2'b00);
    add(0, LW, 1, 1, 2, C_EX_AD, 2, 2'b00);
    add(0, LW, 0, 2, 3, C_M_LW, 2, 2'b00);
    add(0, LW, 1, 1, 3, C_M_LW, 2, 2'b00);
    add(0, LW, 1, 1, 4, C_WB_LW, 2, 2'b00);
    add(0, BEQ, 1, 1, 0, C_FRDY, 3, 2'b00);
    add(0, BEQ, 1, 1, 1, C_DEC, 3, 2'b00);
    add(0, BEQ, 1, 1, 2, C_EX_BQ, 3, 2'b00);
    add(0, ORI, 1, 1, 0, C_FRDY, 4, 2'b00);
    add(0, ORI, 1, 1, 1, C_DEC, 4, 2'b00);
    add(0, ORI, 1, 1, 2, C_EX_OR, 4, 2'b00);
    add(0, ORI, 1, 1, 4, C_WB_I, 4, 2'b00);
    add(0, SW, 1, 1, 0, C_FRDY, 5, 2'b00);
    add(0, SW, 1, 1, 1, C_DEC, 5, 2'b00);
    add(0, SW, 1, 1, 2, C_EX_AD, 5, 2'b00);
    add(0, SW, 1, 1, 3, C_M_SW, 5, 2'b00);
    add(0, JMP, 1, 1, 0, C_FRDY, 6, 2'b00);
    add(0, JMP, 1, 1, 1, C_DEC, 6, 2'b00);
    add(0, JMP, 1, 20, 7, C_NONE, 6, 2'b10);
    add(1, R, 0, 1, 7, C_NONE, 6, 2'b10);
    add(0, R, 0, 16, 0, C_FWAIT, 0, 2'b00);
    add(0, R, 1, 3, 7, C_NONE, 0, 2'b01);
    add(1, R, 0, 1, 7, C_NONE, 0, 2'b01);
    add(0, R, 0, 15, 0, C_FWAIT, 0, 2'b00);
    add(0, R, 1, 1, 0, C_FRDY, 0, 2'b00);
    add(0, R, 1, 1, 1, C_DEC, 0, 2'b00);
    add(0, R, 1, 1, 2, C_EX_R, 0, 2'b00);
    add(0, R, 1, 1, 4, C_WB_R, 0, 2'b00);
    add(0, SW, 1, 1, 0, C_FRDY, 1, 2'b00);
    add(0, SW, 1, 1, 1, C_DEC, 1, 2'b00);
    add(0, SW, 1, 1, 2, C_EX_AD, 1, 2'b00);
    add(0, SW, 0, 1, 3, C_M_SW, 1, 2'b00);
    add(1, SW, 0, 1, 3, C_NONE, 1, 2'b00);
    add(0, SW, 0, 1, 0, C_FWAIT, 0, 2'b00);

    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    n_vec++;
    if (state_o !== 3'd0 || ctrl !== C_NONE ||
        retire_cnt_o !== 32'd0 ||
        illegal_op_o !== 1'b0 ||
        bus_err_o !== 1'b0) begin
      n_bad++;
      $display("FAIL reset: st=%0d ctrl=%h ret=%0d fl=%b",
               state_o, ctrl, retire_cnt_o,
               {illegal_op_o, bus_err_o});
    end

    foreach (tbl[i]) begin
      for (int k = 0; k < tbl[i].rep; k++) begin
        @(negedge clk_i);
        rst_i       = tbl[i].rst;
        instr_op_i  = tbl[i].op;
        mem_ready_i = tbl[i].rdy;
        #1;
        n_vec++;
        if (state_o !== tbl[i].st ||
            ctrl !== tbl[i].c ||
            retire_cnt_o !== tbl[i].ret ||
            {illegal_op_o, bus_err_o} !== tbl[i].fl) begin
          n_bad++;
          $display("FAIL row %0d.%0d: st=%0d ctrl=%h ret=%0d fl=%b want st=%0d ctrl=%h ret=%0d fl=%b",
                   i, k, state_o, ctrl, retire_cnt_o,
                   {illegal_op_o, bus_err_o},
                   tbl[i].st, tbl[i].c,
                   tbl[i].ret, tbl[i].fl);
        end
      end
    end

    @(negedge clk_i);
    rst_i       = 1'b1;
    instr_op_i  = R;
    mem_ready_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;
    repeat (15) @(posedge clk_i);
    #1;
    n_vec++;
    if (state_o !== 3'd0 || bus_err_o !== 1'b0) begin
      n_bad++;
      $display("FAIL pre-timeout: st=%0d err=%b",
               state_o, bus_err_o);
    end
    @(posedge clk_i);
    #1;
    n_vec++;
    if (state_o !== 3'd7 || bus_err_o !== 1'b1 ||
        ctrl !== C_NONE) begin
      n_bad++;
      $display("FAIL timeout: st=%0d err=%b ctrl=%h",
               state_o, bus_err_o, ctrl);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
